// File: rtl/bsk_pc_rd_dispatch.sv
// Read-command dispatcher: spreads one BSK read command round-robin over BSK_PC HBM
// pseudo-channels, bounds in-flight bursts per channel and pulses done on completion.
module bsk_pc_rd_dispatch #(
  parameter int BSK_PC      = 4,
  parameter int AXI_ADD_W   = 64,
  parameter int BURST_LEN   = 16,
  parameter int BURST_BYTES = 1024,
  parameter int MAX_OUTST   = 8,
  parameter int NB_W        = 16
) (
  input  logic                        clk,
  input  logic                        s_rst_n,
  input  logic                        cmd_vld,
  output logic                        cmd_rdy,
  input  logic [AXI_ADD_W-1:0]        cmd_add,
  input  logic [NB_W-1:0]             cmd_nb,
  output logic [BSK_PC*AXI_ADD_W-1:0] m_axi_araddr,
  output logic [BSK_PC*8-1:0]         m_axi_arlen,
  output logic [BSK_PC-1:0]           m_axi_arvalid,
  input  logic [BSK_PC-1:0]           m_axi_arready,
  input  logic [BSK_PC-1:0]           rlast_vld,
  output logic                        done,
  output logic                        err_underflow
);
  localparam int OW = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  logic [NB_W-1:0]      r_quota  [BSK_PC];
  logic [NB_W-1:0]      r_issued [BSK_PC];
  logic [OW-1:0]        r_outst  [BSK_PC];
  logic [AXI_ADD_W-1:0] r_araddr [BSK_PC];
  logic [BSK_PC-1:0]    r_arvalid;
  logic                 r_cmdRdy;
  logic                 r_done;
  logic                 r_errUnderflow;

  logic [NB_W-1:0]      w_quotaNew   [BSK_PC];
  logic [NB_W-1:0]      w_issuedNext [BSK_PC];
  logic [OW-1:0]        w_outstNext  [BSK_PC];
  logic [BSK_PC-1:0]    w_arHs;
  logic [BSK_PC-1:0]    w_underflow;
  logic [BSK_PC-1:0]    w_canIssue;
  logic                 w_cmdHs;
  logic                 w_allIssued;
  logic                 w_allIdle;

  // Burst i of a command goes to channel i mod BSK_PC; one extra bit keeps nb+BSK_PC-1 from wrapping.
  always_comb begin
    w_cmdHs     = cmd_vld & r_cmdRdy;
    w_allIssued = 1'b1;
    w_allIdle   = 1'b1;
    for (int p = 0; p < BSK_PC; p++) begin
      w_quotaNew[p]   = NB_W'(({1'b0, cmd_nb} + (NB_W+1)'(BSK_PC - 1 - p)) / (NB_W+1)'(BSK_PC));
      w_arHs[p]       = r_arvalid[p] & m_axi_arready[p];
      w_issuedNext[p] = r_issued[p] + NB_W'(w_arHs[p]);
      w_underflow[p]  = rlast_vld[p] & ~w_arHs[p] & (r_outst[p] == '0);
      w_outstNext[p]  = r_outst[p];
      if (w_arHs[p] && !rlast_vld[p])
        w_outstNext[p] = r_outst[p] + OW'(1);
      else if (rlast_vld[p] && !w_arHs[p] && r_outst[p] != '0)
        w_outstNext[p] = r_outst[p] - OW'(1);
      w_canIssue[p] = (w_issuedNext[p] < r_quota[p]) && (w_outstNext[p] < OW'(MAX_OUTST));
      if (r_issued[p] != r_quota[p]) w_allIssued = 1'b0;
      if (r_outst[p] != '0)          w_allIdle   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      r_state        <= S_IDLE;
      r_cmdRdy       <= 1'b0;
      r_done         <= 1'b0;
      r_errUnderflow <= 1'b0;
      r_arvalid      <= '0;
      for (int p = 0; p < BSK_PC; p++) begin
        r_quota[p]  <= '0;
        r_issued[p] <= '0;
        r_outst[p]  <= '0;
        r_araddr[p] <= '0;
      end
    end else begin
      r_done         <= 1'b0;
      r_errUnderflow <= r_errUnderflow | (|w_underflow);
      for (int p = 0; p < BSK_PC; p++) begin
        r_outst[p]  <= w_outstNext[p];
        r_issued[p] <= w_issuedNext[p];
        if (w_arHs[p]) r_araddr[p] <= r_araddr[p] + AXI_ADD_W'(BURST_BYTES);
      end
      case (r_state)
        S_IDLE: begin
          r_cmdRdy <= ~w_cmdHs;
          // First AR is launched straight from the handshake edge to save a cycle.
          if (w_cmdHs) begin
            for (int p = 0; p < BSK_PC; p++) begin
              r_quota[p]   <= w_quotaNew[p];
              r_issued[p]  <= '0;
              r_araddr[p]  <= cmd_add;
              r_arvalid[p] <= (w_quotaNew[p] != '0) && (w_outstNext[p] < OW'(MAX_OUTST));
            end
            r_state <= (cmd_nb == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_arvalid <= w_canIssue;
          if (w_allIssued) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_allIdle) r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < BSK_PC; g++) begin : g_ch
    assign m_axi_araddr[g*AXI_ADD_W +: AXI_ADD_W] = r_araddr[g];
    assign m_axi_arlen[g*8 +: 8]                  = 8'(BURST_LEN - 1);
  end

  assign m_axi_arvalid = r_arvalid;
  assign cmd_rdy       = r_cmdRdy;
  assign done          = r_done;
  assign err_underflow = r_errUnderflow;
endmodule

// File: tb/tb_bsk_pc_rd_dispatch.sv
// Scoreboard bench for bsk_pc_rd_dispatch: a burst-list model predicts every AR address,
// an AXI responder returns rlast pulses, and a monitor checks ARs and done as they appear.
module tb_bsk_pc_rd_dispatch;
  localparam int PC   = 4;
  localparam int AW   = 64;
  localparam int NBW  = 16;
  localparam int MAXO = 8;
  localparam int BB   = 1024;

  logic              clk;
  logic              s_rst_n;
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [AW-1:0]     cmd_add;
  logic [NBW-1:0]    cmd_nb;
  logic [PC*AW-1:0]  m_axi_araddr;
  logic [PC*8-1:0]   m_axi_arlen;
  logic [PC-1:0]     m_axi_arvalid;
  logic [PC-1:0]     m_axi_arready;
  logic [PC-1:0]     rlast_vld;
  logic              done;
  logic              err_underflow;

  bsk_pc_rd_dispatch #(
    .BSK_PC(PC), .AXI_ADD_W(AW), .BURST_LEN(16), .BURST_BYTES(BB), .MAX_OUTST(MAXO), .NB_W(NBW)
  ) dut (
    .clk(clk), .s_rst_n(s_rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_add(cmd_add),
    .cmd_nb(cmd_nb), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .rlast_vld(rlast_vld),
    .done(done), .err_underflow(err_underflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Scoreboard: expected AR addresses per channel and one entry per expected done.
  logic [AW-1:0] expAddr [PC][$];
  int            expDone [$];
  int unsigned   dueQ    [PC][$];
  int            tbOutst [PC];
  int            hsCount [PC];
  int            doneSeen = 0;
  int            lastRlastCyc = -1;
  int            hsCyc = -10;
  bit            firstPend = 0;
  logic [PC-1:0] firstMask;
  bit            prevDone = 0;
  logic [PC-1:0] prevValid = '0;
  logic [PC-1:0] prevReady = '0;
  logic [AW-1:0] prevAddr [PC];

  bit            rlastHold = 0;
  logic [PC-1:0] rlastExtra = '0;
  logic [PC-1:0] releaseOne = '0;
  logic [PC-1:0] readyForceLow = '0;
  int            readyPct = 100;
  int            latMin = 1;
  int            latMax = 20;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [AW-1:0] chAddr(input int p);
    return m_axi_araddr[p*AW +: AW];
  endfunction

  // AXI slave: random arready, one rlast per channel per cycle once an AR's latency expires.
  initial begin
    rlast_vld     = '0;
    m_axi_arready = '0;
    forever begin
      @(negedge clk);
      if (s_rst_n)
        for (int p = 0; p < PC; p++)
          if (m_axi_arvalid[p] && m_axi_arready[p])
            dueQ[p].push_back(cyc + $urandom_range(latMax, latMin));
      @(posedge clk);
      #1;
      for (int p = 0; p < PC; p++) begin
        rlast_vld[p] = 1'b0;
        if (dueQ[p].size() > 0 && ((!rlastHold && dueQ[p][0] <= cyc) || releaseOne[p])) begin
          void'(dueQ[p].pop_front());
          rlast_vld[p]  = 1'b1;
          releaseOne[p] = 1'b0;
        end
        if (rlastExtra[p]) rlast_vld[p] = 1'b1;
        m_axi_arready[p] = !readyForceLow[p] && ($urandom_range(99) < readyPct);
      end
      rlastExtra = '0;
    end
  end

  // Monitor: pops expectations whenever the DUT shows an AR handshake or a done pulse.
  initial forever begin
    @(negedge clk);
    if (!s_rst_n) begin
      prevValid = '0;
      prevDone  = 0;
    end else begin
      for (int p = 0; p < PC; p++) begin
        if (prevValid[p] && !prevReady[p]) begin
          checkOutput($sformatf("ar hold valid ch%0d", p), AW'(m_axi_arvalid[p]), 1);
          checkOutput($sformatf("ar hold addr ch%0d", p), chAddr(p), prevAddr[p]);
        end
        if (m_axi_arvalid[p] && m_axi_arready[p]) begin
          hsCount[p]++;
          checkOutput($sformatf("arlen ch%0d", p), AW'(m_axi_arlen[p*8 +: 8]), 15);
          checkOutput($sformatf("outst limit ch%0d", p), AW'(tbOutst[p] < MAXO), 1);
          if (expAddr[p].size() == 0)
            checkOutput($sformatf("unexpected AR ch%0d", p), chAddr(p), '1);
          else
            checkOutput($sformatf("araddr ch%0d", p), chAddr(p), expAddr[p].pop_front());
          tbOutst[p]++;
        end
        if (rlast_vld[p]) begin
          lastRlastCyc = cyc;
          if (tbOutst[p] > 0) tbOutst[p]--;
        end
        prevAddr[p] = chAddr(p);
      end
      prevValid = m_axi_arvalid;
      prevReady = m_axi_arready;
      if (firstPend && cyc == hsCyc + 1) begin
        checkOutput("first arvalid", AW'(m_axi_arvalid), AW'(firstMask));
        firstPend = 0;
      end
      if (cmd_vld && cmd_rdy) begin
        hsCyc     = cyc;
        firstPend = 1;
        for (int p = 0; p < PC; p++) firstMask[p] = expAddr[p].size() > 0;
      end
      if (prevDone) begin
        checkOutput("done width", AW'(done), 0);
        checkOutput("cmd_rdy after done", AW'(cmd_rdy), 1);
      end
      if (done) begin
        checkOutput("cmd_rdy during done", AW'(cmd_rdy), 0);
        if (expDone.size() == 0) begin
          checkOutput("unexpected done", 1, 0);
        end else begin
          int nb;
          bit allDone;
          nb = expDone.pop_front();
          allDone = cyc > lastRlastCyc || nb == 0;
          for (int p = 0; p < PC; p++)
            if (expAddr[p].size() != 0 || tbOutst[p] != 0) allDone = 0;
          checkOutput("done after completion", AW'(allDone), 1);
          if (nb == 0) checkOutput("empty cmd done latency", AW'(cyc - hsCyc), 2);
        end
        doneSeen++;
      end
      prevDone = done;
    end
  end

  // Reference model: burst i of the command lands on channel i mod PC at offset (i div PC) bursts.
  task automatic applyStimulus(input logic [AW-1:0] add, input int nb);
    int n = 0;
    while (!cmd_rdy && n < 200) begin
      tick();
      n++;
    end
    checkOutput("cmd_rdy wait", AW'(cmd_rdy), 1);
    for (int i = 0; i < nb; i++)
      expAddr[i % PC].push_back(add + AW'(i / PC) * AW'(BB));
    expDone.push_back(nb);
    cmd_add = add;
    cmd_nb  = NBW'(nb);
    cmd_vld = 1'b1;
    tick();
    cmd_vld = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int start = doneSeen;
    int n = 0;
    while (doneSeen == start && n < budget) begin
      tick();
      n++;
    end
    checkOutput("done timeout", AW'(doneSeen != start), 1);
  endtask

  initial begin
    logic [AW-1:0] holdAddr;
    int            hsBefore [PC];
    logic [AW-1:0] add;
    s_rst_n = 1'b0;
    cmd_vld = 1'b0;
    cmd_add = '0;
    cmd_nb  = '0;
    for (int p = 0; p < PC; p++) begin
      tbOutst[p] = 0;
      hsCount[p] = 0;
    end
    repeat (3) tick();
    checkOutput("reset cmd_rdy", AW'(cmd_rdy), 0);
    checkOutput("reset arvalid", AW'(m_axi_arvalid), 0);
    checkOutput("reset done", AW'(done), 0);
    checkOutput("reset err", AW'(err_underflow), 0);
    checkOutput("reset araddr ch0", chAddr(0), 0);
    checkOutput("reset araddr ch3", chAddr(3), 0);
    checkOutput("reset arlen", AW'(m_axi_arlen), AW'(32'h0F0F0F0F));
    s_rst_n = 1'b1;
    tick();
    checkOutput("cmd_rdy after reset", AW'(cmd_rdy), 1);

    $display("[TB] eight bursts, fixed 20-cycle read latency");
    latMin = 20; latMax = 20; readyPct = 100;
    applyStimulus(64'h1000, 8);
    waitDone(500);

    $display("[TB] five bursts, uneven quotas");
    latMin = 1; latMax = 8;
    applyStimulus(64'h0, 5);
    waitDone(500);

    $display("[TB] empty command");
    applyStimulus(64'h5000, 0);
    waitDone(20);

    $display("[TB] outstanding limit with rlast withheld");
    rlastHold = 1;
    applyStimulus(64'h8000, 40);
    repeat (30) tick();
    checkOutput("stall arvalid", AW'(m_axi_arvalid), 0);
    for (int p = 0; p < PC; p++) begin
      checkOutput($sformatf("stall outst ch%0d", p), AW'(tbOutst[p]), MAXO);
      checkOutput($sformatf("stall issued ch%0d", p), AW'(expAddr[p].size()), 2);
    end
    releaseOne[2] = 1'b1;
    repeat (6) tick();
    for (int p = 0; p < PC; p++)
      checkOutput($sformatf("release remaining ch%0d", p), AW'(expAddr[p].size()), (p == 2) ? 1 : 2);
    checkOutput("release arvalid", AW'(m_axi_arvalid), 0);
    rlastHold = 0;
    waitDone(2000);

    $display("[TB] channel 1 back-pressured");
    readyForceLow = 4'b0010;
    latMin = 1; latMax = 4;
    applyStimulus(64'h3_0000_0000, 24);
    holdAddr = chAddr(1);
    for (int p = 0; p < PC; p++) hsBefore[p] = hsCount[p];
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp arvalid ch1", AW'(m_axi_arvalid[1]), 1);
      checkOutput("bp araddr ch1", chAddr(1), holdAddr);
      tick();
    end
    checkOutput("bp others ch0", AW'(hsCount[0] > hsBefore[0]), 1);
    checkOutput("bp others ch2", AW'(hsCount[2] > hsBefore[2]), 1);
    checkOutput("bp others ch3", AW'(hsCount[3] > hsBefore[3]), 1);
    readyForceLow = '0;
    waitDone(2000);

    $display("[TB] randomized commands");
    for (int k = 0; k < 12; k++) begin
      readyPct = $urandom_range(100, 30);
      latMin   = 1;
      latMax   = $urandom_range(20, 1);
      add      = {$urandom(), $urandom()};
      if (k == 0) add = 64'hFFFF_FFFF_FFFF_F800;
      applyStimulus(add, $urandom_range(60, 0));
      waitDone(3000);
    end
    checkOutput("no underflow in normal traffic", AW'(err_underflow), 0);

    $display("[TB] spurious rlast in idle");
    readyPct = 100;
    rlastExtra[3] = 1'b1;
    repeat (3) tick();
    checkOutput("underflow set", AW'(err_underflow), 1);
    repeat (5) tick();
    checkOutput("underflow sticky", AW'(err_underflow), 1);

    $display("[TB] reset during issue");
    rlastHold = 1;
    applyStimulus(64'h9000, 40);
    repeat (3) tick();
    s_rst_n = 1'b0;
    for (int p = 0; p < PC; p++) begin
      expAddr[p].delete();
      dueQ[p].delete();
      tbOutst[p] = 0;
    end
    expDone.delete();
    firstPend = 0;
    rlastHold = 0;
    tick();
    checkOutput("reset mid arvalid", AW'(m_axi_arvalid), 0);
    checkOutput("reset mid cmd_rdy", AW'(cmd_rdy), 0);
    s_rst_n = 1'b1;
    tick();
    checkOutput("reset mid cmd_rdy release", AW'(cmd_rdy), 1);
    checkOutput("reset mid err cleared", AW'(err_underflow), 0);
    applyStimulus(64'h2000, 7);
    waitDone(500);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bsk_pc_rd_dispatch.md
Name: bsk_pc_rd_dispatch

Overview:
- Read-command dispatcher between the BSK manager and the HBM AXI read ports.
- Takes one BSK read command (base address, number of bursts) and spreads the bursts round-robin over BSK_PC pseudo-channels.
- Enforces a per-channel outstanding-burst limit, counts returned bursts, and pulses done when the whole command has completed.
- BSK_PC defaults to the platform BSK_PC_MAX (4).

Parameters:
- BSK_PC, 4: number of BSK pseudo-channels driven (1..4).
- AXI_ADD_W, 64: AXI address width.
- BURST_LEN, 16: beats per burst; arlen = BURST_LEN-1.
- BURST_BYTES, 1024: address increment between consecutive bursts on one channel.
- MAX_OUTST, 8: maximum in-flight bursts per channel.
- NB_W, 16: width of the burst-count field.

Ports:
- clk  in  1  clock
- s_rst_n  in  1  synchronous active-low reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready
- cmd_add  in  AXI_ADD_W  base address, the same offset in every channel
- cmd_nb  in  NB_W  total bursts in the command
- m_axi_araddr  out  BSK_PC*AXI_ADD_W  per-channel AR address
- m_axi_arlen  out  BSK_PC*8  per-channel AR length
- m_axi_arvalid  out  BSK_PC  per-channel AR valid
- m_axi_arready  in  BSK_PC  per-channel AR ready
- rlast_vld  in  BSK_PC  1-cycle pulse per completed burst (R handshake with rlast)
- done  out  1  1-cycle pulse when the command has fully completed
- err_underflow  out  1  sticky: rlast_vld seen on a channel with 0 outstanding

Behaviour:
- Reset values:
  - cmd_rdy=0, arvalid=0, araddr=0, arlen=BURST_LEN-1 (constant), done=0, err_underflow=0.
  - All counters 0, FSM=IDLE.
  - Reset mid-command drops all state immediately; no AR is held across reset.
- FSM:
  - IDLE:
    - cmd_rdy=1.
    - On cmd_vld&cmd_rdy, latch cmd_add and cmd_nb.
    - Per channel p, compute quota_p = number of i in [0,cmd_nb) with i mod BSK_PC == p, i.e. floor((cmd_nb+BSK_PC-1-p)/BSK_PC).
    - Go to ISSUE.
    - If cmd_nb==0, go to DONE instead.
  - ISSUE:
    - cmd_rdy=0.
    - For each p independently: arvalid_p=1 while issued_p<quota_p and outst_p<MAX_OUTST.
    - araddr_p = cmd_add + issued_p*BURST_BYTES.
    - On arvalid_p&arready_p: issued_p++ and outst_p++.
    - Once arvalid_p rises, arvalid_p and araddr_p stay stable until arready_p (AXI rule); they are registered outputs.
    - When issued_p==quota_p for all p, go to DRAIN.
  - DRAIN:
    - No AR issued.
    - When outst_p==0 for all p, go to DONE.
  - DONE:
    - done=1 for exactly one cycle, then IDLE.
    - cmd_rdy rises the cycle after done.
- Outstanding counting:
  - rlast_vld_p decrements outst_p in any state.
  - Same-cycle AR handshake and rlast_vld_p on one channel leaves outst_p unchanged.
  - rlast_vld_p with outst_p==0 (and no same-cycle AR handshake) sets err_underflow and leaves outst_p=0.
  - err_underflow clears only on reset.
- Minimum latency:
  - cmd handshake at cycle t gives first arvalid at t+1.
  - done no earlier than one cycle after the final rlast_vld.
- Widths:
  - Outstanding counters are clog2(MAX_OUTST+1) bits.
  - issued_p and quota_p are NB_W bits.
  - Address addition is modulo 2^AXI_ADD_W.
- Channels are fully independent: a back-pressured channel never stalls issue on the others.

Test Plan:
- cmd_nb=8, BSK_PC=4, cmd_add=0x1000, arready=1, rlast 20 cycles after each AR -> 2 ARs per channel at 0x1000 and 0x1400; a single done pulse after the last rlast; cmd_rdy=1 the cycle after done.
- cmd_nb=5 -> quotas 2,1,1,1; ch0 addresses 0x0 and 0x400, the others 0x0 only; done after 5 rlast pulses.
- cmd_nb=40, MAX_OUTST=8, rlast withheld -> each channel stalls with outst=8 and arvalid=0; releasing one rlast on ch2 yields exactly one new AR on ch2 only.
- arready_1 held low for 10 cycles -> arvalid_1 and araddr_1 stable for all 10 cycles; ch0, ch2 and ch3 keep issuing.
- cmd_nb=0 -> done pulse 2 cycles after the cmd handshake; no arvalid ever asserted.
- Edge cases:
  - Same-cycle AR handshake and rlast_vld on ch0 -> outst_0 unchanged.
  - Spurious rlast_vld_3 in IDLE -> err_underflow=1 and stays set.
  - s_rst_n=0 during ISSUE -> the next cycle has all arvalid=0 and cmd_rdy=0; cmd_rdy=1 once reset is released.
